// File: rtl/uart_rx_deserializer.sv
// UART receive front end: synchronizes rx_i, oversamples on the 16x baud tick and deserializes 5-8N/E/O/stick-parity frames.
// Optional `UART_RX_MAJORITY_EN: 3-sample majority vote per bit instead of a single centre sample.
module uart_rx_deserializer #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       baud_tick_i,
  input  logic       rx_i,
  input  logic [7:0] lcr_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       pe_o,
  output logic       fe_o,
  output logic       bi_o,
  output logic       oe_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} state_e;

  state_e state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic       rx_s;
  logic [3:0] tcnt_q;
  logic [2:0] bcnt_q;
  logic [7:0] shift_q;
  logic [1:0] wl_q;
  logic       pen_q, eps_q, stick_q, par_bit_q;
  logic       pend_q, pend_pe_q, pend_fe_q, pend_bi_q;
  logic [7:0] pend_data_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q, pe_q, fe_q, bi_q, oe_q;
  logic       decide, bitv;
  logic [3:0] dec_t;
  logic [2:0] last_bit;
  logic       exp_par;
  logic       latch_lcr, start_ok, data_en, par_en, stop_en;
  logic       unused_lcr;

  assign unused_lcr = ^{lcr_i[7:6], lcr_i[2]};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end
  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  // Decision lands one tick after the bit centre; START reloads tcnt to 1 to keep later centres aligned.
  localparam logic [3:0] START_RELOAD = 4'd1;
  logic [1:0] maj_q;
  logic [3:0] first_t;
  always_comb begin
    first_t = (state_q == S_START) ? 4'd6 : 4'd14;
    dec_t   = first_t + 4'd2;
    bitv    = (maj_q[0] & maj_q[1]) | (rx_s & (maj_q[0] | maj_q[1]));
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      maj_q <= '0;
    end else if (baud_tick_i) begin
      if (tcnt_q == first_t)         maj_q[0] <= rx_s;
      if (tcnt_q == first_t + 4'd1)  maj_q[1] <= rx_s;
    end
  end
`else
  localparam logic [3:0] START_RELOAD = 4'd0;
  always_comb begin
    dec_t = (state_q == S_START) ? 4'd7 : 4'd15;
    bitv  = rx_s;
  end
`endif

  assign decide   = baud_tick_i && (tcnt_q == dec_t);
  assign last_bit = 3'd4 + {1'b0, wl_q};
  assign exp_par  = stick_q ? ~eps_q : (eps_q ? ^shift_q : ~(^shift_q));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (!rx_s) state_d = S_START;
      S_START:     if (decide) state_d = bitv ? S_IDLE : S_DATA;
      S_DATA:      if (decide && bcnt_q == last_bit) state_d = pen_q ? S_PARITY : S_STOP;
      S_PARITY:    if (decide) state_d = S_STOP;
      S_STOP:      if (decide) state_d = bitv ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rx_s) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (state_q != S_IDLE);
    latch_lcr = (state_q == S_IDLE) && !rx_s;
    start_ok  = (state_q == S_START) && decide && !bitv;
    data_en   = (state_q == S_DATA) && decide;
    par_en    = (state_q == S_PARITY) && decide;
    stop_en   = (state_q == S_STOP) && decide;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tcnt_q <= '0; bcnt_q <= '0; shift_q <= '0;
      wl_q <= '0; pen_q <= 1'b0; eps_q <= 1'b0; stick_q <= 1'b0; par_bit_q <= 1'b0;
      pend_q <= 1'b0; pend_data_q <= '0; pend_pe_q <= 1'b0; pend_fe_q <= 1'b0; pend_bi_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE)    tcnt_q <= '0;
      else if (baud_tick_i)     tcnt_q <= ((state_q == S_START) && decide) ? START_RELOAD : tcnt_q + 4'd1;
      if (latch_lcr) begin
        wl_q <= lcr_i[1:0]; pen_q <= lcr_i[3]; eps_q <= lcr_i[4]; stick_q <= lcr_i[5];
      end
      if (start_ok) begin
        bcnt_q  <= '0;
        shift_q <= '0;
      end
      if (data_en) begin
        shift_q[bcnt_q] <= bitv;
        bcnt_q          <= bcnt_q + 3'd1;
      end
      if (par_en) par_bit_q <= bitv;
      pend_q <= stop_en;
      if (stop_en) begin
        pend_data_q <= shift_q;
        pend_fe_q   <= ~bitv;
        pend_pe_q   <= pen_q && (par_bit_q != exp_par);
        pend_bi_q   <= (shift_q == 8'h00) && !(pen_q && par_bit_q) && !bitv;
      end
    end
  end

  // A commit may reuse the holding register in the same cycle the old character is accepted.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_data_q <= '0; rx_valid_q <= 1'b0; pe_q <= 1'b0; fe_q <= 1'b0; bi_q <= 1'b0; oe_q <= 1'b0;
    end else begin
      oe_q <= 1'b0;
      if (pend_q) begin
        if (!rx_valid_q || rx_ready_i) begin
          rx_data_q  <= pend_data_q;
          pe_q       <= pend_pe_q;
          fe_q       <= pend_fe_q;
          bi_q       <= pend_bi_q;
          rx_valid_q <= 1'b1;
        end else begin
          oe_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready_i) begin
        rx_data_q <= '0; pe_q <= 1'b0; fe_q <= 1'b0; bi_q <= 1'b0; rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign pe_o       = pe_q;
  assign fe_o       = fe_q;
  assign bi_o       = bi_q;
  assign oe_o       = oe_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: directed scenarios plus randomized frames against a frame-level model.
module tb_uart_rx_deserializer;
  logic clk = 1'b0, rst_n = 1'b0, baud_tick = 1'b0, rx = 1'b1, rx_ready = 1'b1;
  logic [7:0] lcr = 8'h03;
  logic [7:0] rx_data;
  logic rx_valid, pe, fe, bi, oe, busy;
  int unsigned div = 16;
  int unsigned tb_cnt = 0;
  int checks = 0, errors = 0, oe_cnt = 0;
  logic [10:0] rxq[$];

  uart_rx_deserializer #(.SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .baud_tick_i(baud_tick), .rx_i(rx), .lcr_i(lcr),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .pe_o(pe), .fe_o(fe), .bi_o(bi), .oe_o(oe), .busy_o(busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      if (tb_cnt >= div - 1) begin baud_tick = 1'b1; tb_cnt = 0; end
      else begin baud_tick = 1'b0; tb_cnt++; end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready) rxq.push_back({rx_data, pe, fe, bi});
    if (rst_n && oe) oe_cnt++;
  end

  // Frame-level model: {data, pe, fe, bi}
  function automatic logic [10:0] ref_char(input logic [7:0] l, input logic [7:0] d,
                                           input logic pbit, input logic sbit);
    int wl;
    logic [7:0] md;
    logic ev, expp, p_e, b_i;
    wl   = 5 + int'(l[1:0]);
    md   = d & 8'((1 << wl) - 1);
    ev   = ($countones(md) % 2) == 1;
    expp = l[5] ? !l[4] : (l[4] ? ev : !ev);
    p_e  = l[3] && (pbit != expp);
    b_i  = (md == 8'h00) && (!l[3] || !pbit) && !sbit;
    return {md, p_e, !sbit, b_i};
  endfunction

  function automatic logic good_par(input logic [7:0] l, input logic [7:0] d);
    logic [10:0] r0;
    r0 = ref_char(l, d, 1'b0, 1'b1);
    return r0[2];
  endfunction

  task automatic tick_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!baud_tick) @(posedge clk);
    end
    #1;
  endtask

  // Drives start/data/parity then the stop level, returning just after the stop-sample edge.
  task automatic send_head(input logic [7:0] l, input logic [7:0] d, input logic pbit, input logic sbit);
    int wl;
    wl = 5 + int'(l[1:0]);
    tick_wait(1);
    lcr = l;
    rx = 1'b0;
    tick_wait(16);
    lcr = 8'($urandom);
    for (int i = 0; i < wl; i++) begin rx = d[i]; tick_wait(16); end
    if (l[3]) begin rx = pbit; tick_wait(16); end
    rx = sbit;
    tick_wait(8);
  endtask

  task automatic send_frame(input logic [7:0] l, input logic [7:0] d, input logic pbit,
                            input logic sbit, input int idle);
    send_head(l, d, pbit, sbit);
    tick_wait(8);
    rx = 1'b1;
    tick_wait(idle);
  endtask

  task automatic check_one(input string name, input logic [10:0] exp);
    checks++;
    if (rxq.size() != 1) begin
      errors++;
      $display("FAIL %s count got %0d want 1", name, rxq.size());
    end else begin
      checks++;
      if (rxq[0] !== exp) begin
        errors++;
        $display("FAIL %s char got %h want %h", name, rxq[0], exp);
      end
    end
    rxq.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", rx_data); end
    checks++; if ({pe, fe, bi, oe} !== 4'b0) begin errors++; $display("FAIL rst_flags got %b want 0000", {pe, fe, bi, oe}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    tick_wait(1);
    lcr = 8'h03; rx = 1'b0;
    tick_wait(40);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_pre got %b want 1", busy); end
    rst_n = 1'b0; rx = 1'b1;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    tick_wait(160);
    checks++; if (rxq.size() != 0) begin errors++; $display("FAIL midrst_output got %0d want 0", rxq.size()); end
    rxq.delete();
  endtask

  task automatic test_8n1_timing();
    div = 16;
    send_head(8'h03, 8'h55, 1'b0, 1'b1);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL t8n1_early got %b want 0", rx_valid); end
    @(posedge clk); #1;
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL t8n1_rise got %b want 1", rx_valid); end
    checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL t8n1_data got %h want 55", rx_data); end
    checks++; if ({pe, fe, bi} !== 3'b000) begin errors++; $display("FAIL t8n1_flags got %b want 000", {pe, fe, bi}); end
    tick_wait(8);
    rxq.delete();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL t8n1_drop got %b want 0", rx_valid); end
    div = 4;
    tick_wait(2);
  endtask

  task automatic test_parity();
    send_frame(8'h1A, 8'h41, 1'b1, 1'b1, 2);
    check_one("p7e1", ref_char(8'h1A, 8'h41, 1'b1, 1'b1));
    send_frame(8'h08, 8'h1F, good_par(8'h08, 8'h1F), 1'b1, 2);
    check_one("p5o1", {8'h1F, 3'b000});
    send_frame(8'h38, 8'hC3, 1'b0, 1'b1, 2);
    check_one("pstick", ref_char(8'h38, 8'hC3, 1'b0, 1'b1));
  endtask

  task automatic test_false_start();
    tick_wait(1);
    rx = 1'b0;
    tick_wait(5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fs_busy_pre got %b want 1", busy); end
    rx = 1'b1;
    tick_wait(6);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fs_busy got %b want 0", busy); end
    tick_wait(160);
    checks++; if (rxq.size() != 0) begin errors++; $display("FAIL fs_output got %0d want 0", rxq.size()); end
    rxq.delete();
  endtask

  task automatic test_break();
    tick_wait(1);
    lcr = 8'h03; rx = 1'b0;
    tick_wait(480);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL brk_busy got %b want 1", busy); end
    check_one("brk", {8'h00, 3'b011});
    rx = 1'b1;
    tick_wait(4);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL brk_idle got %b want 0", busy); end
    send_frame(8'h03, 8'h5A, 1'b0, 1'b1, 2);
    check_one("brk_next", {8'h5A, 3'b000});
  endtask

  task automatic test_back_to_back();
    int oe0;
    rx_ready = 1'b0; rxq.delete(); oe0 = oe_cnt;
    send_frame(8'h03, 8'hA5, 1'b0, 1'b1, 0);
    send_frame(8'h03, 8'h3C, 1'b0, 1'b1, 2);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", rx_valid); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL ovr_data got %h want a5", rx_data); end
    checks++; if (oe_cnt - oe0 != 1) begin errors++; $display("FAIL ovr_oe got %0d want 1", oe_cnt - oe0); end
    rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
    checks++; if ({rx_valid, rx_data} !== 9'h000) begin errors++; $display("FAIL ovr_clear got %h want 000", {rx_valid, rx_data}); end
    rxq.delete();
    send_frame(8'h03, 8'hA5, 1'b0, 1'b1, 0);
    oe0 = oe_cnt;
    send_head(8'h03, 8'h3C, 1'b0, 1'b1);
    rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL acc_data got %h want 3c", rx_data); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL acc_valid got %b want 1", rx_valid); end
    tick_wait(8);
    checks++; if (oe_cnt != oe0) begin errors++; $display("FAIL acc_oe got %0d want %0d", oe_cnt, oe0); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL acc_hold got %h want 3c", rx_data); end
    rx_ready = 1'b1;
    tick_wait(1);
    rxq.delete();
  endtask

  task automatic test_glitch();
    logic [7:0] exp;
`ifdef UART_RX_MAJORITY_EN
    exp = 8'hFF;
`else
    exp = 8'hF7;
`endif
    tick_wait(1);
    lcr = 8'h03; rx = 1'b0;
    tick_wait(16);
    rx = 1'b1;
    tick_wait(55);
    rx = 1'b0;
    tick_wait(1);
    rx = 1'b1;
    tick_wait(8 + 64 + 16 + 4);
    check_one("glitch", {exp, 3'b000});
  endtask

  task automatic test_random();
    logic [7:0] l, d;
    logic pb, sb;
    for (int i = 0; i < 14; i++) begin
      l  = 8'($urandom);
      d  = 8'($urandom);
      pb = 1'($urandom);
      sb = ($urandom_range(0, 4) != 0);
      if (i % 5 == 4) d = 8'h00;
      send_frame(l, d, pb, sb, 3);
      check_one("rand", ref_char(l, d, pb, sb));
    end
  endtask

  initial begin
    test_reset();
    test_8n1_timing();
    test_parity();
    test_false_start();
    test_break();
    test_back_to_back();
    test_glitch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
